// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: pulls a fixed-length burst of words out of a synchronous
// FIFO and replays them on a valid/ready stream. A 2-entry skid buffer hides
// the FIFO's one-cycle read latency so a word can move every cycle.
module fifo_burst_reader #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  Empty,
    output logic                  Read_EN,
    input  logic [DATA_WIDTH-1:0] Read_Data,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   burst_len,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   words_read
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH:0]   r_remaining;
    logic [ADDR_WIDTH:0]   r_words_read;
    logic [ADDR_WIDTH:0]   w_rem_nxt;
    logic                  r_inflight;
    logic [1:0]            r_occ;
    logic [1:0]            w_occ_nxt;
    logic [2:0]            w_outstanding;
    logic [DATA_WIDTH-1:0] r_buf0;
    logic [DATA_WIDTH-1:0] r_buf1;
    logic                  w_rd;
    logic                  w_pop;
    logic                  w_push;

    localparam logic [ADDR_WIDTH:0] CNT_ZERO = {(ADDR_WIDTH+1){1'b0}};
    localparam logic [ADDR_WIDTH:0] CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    assign w_pop         = (r_occ != 2'd0) && out_ready;
    assign w_push        = r_inflight;
    assign w_outstanding = {1'b0, r_occ} + {2'b00, r_inflight};

    assign Read_EN    = w_rd;
    assign out_valid  = (r_occ != 2'd0);
    assign out_data   = r_buf0;
    assign busy       = (r_state != ST_IDLE);
    assign done       = (r_state == ST_DONE);
    assign words_read = r_words_read;

    // Read issue: only in READ, with words left, FIFO non-empty and a free buffer slot guaranteed.
    always_comb begin
        w_rd = 1'b0;
        if ((r_state == ST_READ) && (r_remaining != CNT_ZERO) && !Empty &&
            ((w_outstanding < 3'd2) || w_pop)) begin
            w_rd = 1'b1;
        end else begin
            w_rd = 1'b0;
        end
    end

    // Remaining count after this cycle's read and buffer occupancy after this cycle's push/pop.
    always_comb begin
        w_rem_nxt = r_remaining;
        w_occ_nxt = r_occ;
        if (w_rd) begin
            w_rem_nxt = r_remaining - CNT_ONE;
        end else begin
            w_rem_nxt = r_remaining;
        end
        case ({w_push, w_pop})
            2'b10:   w_occ_nxt = r_occ + 2'd1;
            2'b01:   w_occ_nxt = r_occ - 2'd1;
            default: w_occ_nxt = r_occ;
        endcase
    end

    // Next-state logic for the burst sequencer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (burst_len == CNT_ZERO) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_READ;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_READ: begin
                if (w_rem_nxt == CNT_ZERO) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_state_nxt = ST_READ;
                end
            end
            ST_DRAIN: begin
                // With nothing in flight there is no push, so occupancy only falls.
                if (!r_inflight && (w_occ_nxt == 2'd0)) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Burst counters and the in-flight read marker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_remaining  <= CNT_ZERO;
            r_words_read <= CNT_ZERO;
            r_inflight   <= 1'b0;
        end else begin
            r_inflight <= w_rd;
            if ((r_state == ST_IDLE) && start) begin
                r_remaining  <= burst_len;
                r_words_read <= CNT_ZERO;
            end else if (w_rd) begin
                r_remaining  <= w_rem_nxt;
                r_words_read <= r_words_read + CNT_ONE;
            end
        end
    end

    // Two-entry output buffer; buf0 is the head and keeps its value when the buffer empties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ  <= 2'd0;
            r_buf0 <= {DATA_WIDTH{1'b0}};
            r_buf1 <= {DATA_WIDTH{1'b0}};
        end else begin
            r_occ <= w_occ_nxt;
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_buf0 <= Read_Data;
                    end else begin
                        r_buf1 <= Read_Data;
                    end
                end
                2'b01: begin
                    if (r_occ == 2'd2) begin
                        r_buf0 <= r_buf1;
                    end
                end
                2'b11: begin
                    if (r_occ == 2'd2) begin
                        r_buf0 <= r_buf1;
                        r_buf1 <= Read_Data;
                    end else begin
                        r_buf0 <= Read_Data;
                    end
                end
                default: begin
                    r_buf0 <= r_buf0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: a behavioural FIFO feeds the DUT, a queue of
// written words is the reference for stream order, and cycle counts are
// checked against the start-to-output and start-to-done latencies.
module tb_fifo_burst_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Empty;
    logic        Read_EN;
    logic [15:0] Read_Data;
    logic        start;
    logic [5:0]  burst_len;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic [5:0]  words_read;

    logic        wr_en;
    logic [15:0] wr_data;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] exp_q[$];
    int          got_cnt;
    int          issued;
    int          delivered;
    bit          stall_prev;
    bit          have_prev;
    logic [15:0] stall_data;
    logic [15:0] prev_data;

    fifo_burst_reader #(.ADDR_WIDTH(5), .DATA_WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Empty     (Empty),
        .Read_EN   (Read_EN),
        .Read_Data (Read_Data),
        .start     (start),
        .burst_len (burst_len),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .words_read(words_read)
    );

    always #5 clk = ~clk;

    // Behavioural 32-deep FIFO with one-cycle read latency.
    logic [15:0] fmem [0:31];
    int          f_wp;
    int          f_rp;
    int          f_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_wp      <= 0;
            f_rp      <= 0;
            f_cnt     <= 0;
            Read_Data <= 16'h0000;
        end else begin
            if (wr_en) begin
                fmem[f_wp % 32] <= wr_data;
                f_wp <= f_wp + 1;
            end
            if (Read_EN && f_cnt != 0) begin
                Read_Data <= fmem[f_rp % 32];
                f_rp <= f_rp + 1;
            end
            f_cnt <= f_cnt + (wr_en ? 1 : 0) - ((Read_EN && f_cnt != 0) ? 1 : 0);
        end
    end
    assign Empty = (f_cnt == 0);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Stream and FIFO-port monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
            have_prev  = 1'b0;
            issued     = 0;
            delivered  = 0;
        end else begin
            if (Read_EN) begin
                chk("ren_while_empty", {31'd0, Empty}, 32'd0);
                chk("ren_outside_read", {31'd0, busy && !done}, 32'd1);
            end
            if (busy) chk("outstanding_le2", {31'd0, (issued - delivered) <= 2}, 32'd1);
            if (stall_prev) begin
                chk("stall_valid", {31'd0, out_valid}, 32'd1);
                chk("stall_data", {16'd0, out_data}, {16'd0, stall_data});
            end
            if (!out_valid && have_prev) chk("hold_idle_data", {16'd0, out_data}, {16'd0, prev_data});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("extra_word", 32'd1, 32'd0);
                else chk("word_order", {16'd0, out_data}, {16'd0, exp_q.pop_front()});
                delivered++;
                got_cnt++;
            end
            if (Read_EN) issued++;
            stall_prev = out_valid && !out_ready;
            stall_data = out_data;
            prev_data  = out_data;
            have_prev  = 1'b1;
        end
    end

    // Write n words into the FIFO (base<0: random data, else base, base+1, ...).
    task automatic preload(input int n, input int base);
        logic [15:0] d;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            d = (base < 0) ? 16'($urandom) : 16'(base + i);
            wr_en   = 1'b1;
            wr_data = d;
            exp_q.push_back(d);
        end
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    // One burst. mode: 0 ready high, 1 ready toggling 1,0,1,0.., 2 random ready.
    task automatic run_burst(input int len, input int mode, input int late_n,
                             input int late_at, input bit poke, input bit chk_lat);
        int          ren_n;
        int          first_v;
        int          done_c;
        int          late_left;
        logic [15:0] d;
        @(posedge clk); #1;
        start     = 1'b1;
        burst_len = 6'(len);
        out_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        got_cnt   = 0;
        @(negedge clk);
        chk("busy_before_burst", {31'd0, busy}, 32'd0);
        chk("ren_cycle0", {31'd0, Read_EN}, 32'd0);
        ren_n     = 0;
        first_v   = -1;
        done_c    = -1;
        late_left = late_n;
        for (int k = 1; k <= 400 && done_c < 0; k++) begin
            @(posedge clk); #1;
            start     = poke && (k == 3);
            burst_len = (poke && k == 3) ? 6'd5 : 6'(len);
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (k % 2 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (late_left > 0 && k >= late_at) begin
                d       = 16'($urandom);
                wr_en   = 1'b1;
                wr_data = d;
                exp_q.push_back(d);
                late_left--;
            end else begin
                wr_en = 1'b0;
            end
            @(negedge clk);
            if (Read_EN) ren_n++;
            if (out_valid && first_v < 0) first_v = k;
            if (done) done_c = k;
        end
        start = 1'b0;
        wr_en = 1'b0;
        if (done_c < 0) begin
            chk("done_timeout", 32'd0, 32'd1);
        end else begin
            chk("words_read", {26'd0, words_read}, 32'(len));
            chk("ren_count", 32'(ren_n), 32'(len));
            chk("delivered", 32'(got_cnt), 32'(len));
            chk("busy_at_done", {31'd0, busy}, 32'd1);
            chk("ref_queue_empty", 32'(exp_q.size()), 32'd0);
            if (chk_lat) begin
                chk("done_cycle", 32'(done_c), (len == 0) ? 32'd1 : 32'(len + 3));
                chk("first_valid", 32'(first_v), (len == 0) ? 32'hFFFF_FFFF : 32'd3);
            end
        end
    endtask

    initial begin
        int len;
        int p;
        rst_n     = 1'b0;
        start     = 1'b0;
        burst_len = 6'd0;
        out_ready = 1'b0;
        wr_en     = 1'b0;
        wr_data   = 16'h0000;
        got_cnt   = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_read_en", {31'd0, Read_EN}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {16'd0, out_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_words_read", {26'd0, words_read}, 32'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;

        // Basic burst of 1..4 with ready held high, then the same with ready toggling.
        preload(4, 1);
        run_burst(4, 0, 0, 0, 1'b0, 1'b1);
        preload(4, 1);
        run_burst(4, 1, 0, 0, 1'b1, 1'b0);

        // FIFO holds one word; the other two arrive ten cycles in.
        preload(1, -1);
        run_burst(3, 0, 2, 10, 1'b0, 1'b0);
        // Zero-length burst, back to back with the previous one.
        run_burst(0, 0, 0, 0, 1'b0, 1'b1);
        @(negedge clk);
        chk("busy_after_done", {31'd0, busy}, 32'd0);

        // Full FIFO, full-length burst.
        preload(32, -1);
        run_burst(32, 0, 0, 0, 1'b0, 1'b1);
        @(negedge clk);
        chk("empty_after_full", {31'd0, Empty}, 32'd1);

        // Reset in the middle of a burst.
        preload(8, -1);
        @(posedge clk); #1;
        start     = 1'b1;
        burst_len = 6'd8;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("busy_mid_burst", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("arst_read_en", {31'd0, Read_EN}, 32'd0);
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_out_data", {16'd0, out_data}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        chk("arst_words_read", {26'd0, words_read}, 32'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        preload(5, -1);
        run_burst(5, 0, 0, 0, 1'b0, 1'b1);

        // Randomized bursts: random length, partial preload, late writes, random ready.
        for (int b = 0; b < 24; b++) begin
            len = $urandom_range(0, 32);
            p   = $urandom_range(0, len);
            if (p > 0) preload(p, -1);
            run_burst(len, 2, len - p, $urandom_range(1, 15), 1'($urandom_range(0, 1)), 1'b0);
        end

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_burst_reader.md
# fifo_burst_reader

Read-side controller for the team's synchronous FIFO. On a `start` command it pulls exactly `burst_len` words out of the FIFO through its `Empty`/`Read_EN` port and presents them downstream on a valid/ready stream. A 2-entry output buffer absorbs the FIFO's one-cycle read latency, so the block sustains one word per cycle. It never issues a read to an empty FIFO.

## Interface
Parameters:
- `ADDR_WIDTH`, 5: FIFO address width. FIFO depth is 2**ADDR_WIDTH.
- `DATA_WIDTH`, 16: FIFO and stream data width.

Ports:
- `clk`  in  1: single clock. All logic is on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `Empty`  in  1: FIFO empty flag.
- `Read_EN`  out  1: FIFO read strobe. The FIFO pops one word per cycle while this is high.
- `Read_Data`  in  DATA_WIDTH: FIFO read data, valid the cycle after `Read_EN`.
- `start`  in  1: one-cycle burst request. Sampled only in IDLE.
- `burst_len`  in  ADDR_WIDTH+1: number of words to read, 0..2**ADDR_WIDTH. Sampled with `start`.
- `out_data`  out  DATA_WIDTH: stream data.
- `out_valid`  out  1: stream valid.
- `out_ready`  in  1: downstream ready.
- `busy`  out  1: high from the cycle after an accepted `start` until `done`, inclusive.
- `done`  out  1: one-cycle pulse when the burst completes.
- `words_read`  out  ADDR_WIDTH+1: number of FIFO reads issued in the current or last burst.

## Operation
- States:
  - IDLE: waits for `start`.
    - `start` with `burst_len`=0 goes to DONE.
    - `start` with `burst_len`>0 latches `remaining`=`burst_len`, clears `words_read`, and goes to READ.
  - READ: issues reads. When `remaining` reaches 0 it goes to DRAIN.
  - DRAIN: waits until the in-flight read has landed and the buffer is empty, then goes to DONE.
  - DONE: `done`=1 for one cycle, then IDLE.
- `start` is ignored outside IDLE.
- Read issue rule, combinational: `Read_EN` = (state==READ) && `remaining`>0 && !`Empty` && (occ + inflight < 2 || (`out_valid` && `out_ready`)).
  - `occ` is the buffer occupancy, 0..2.
  - `inflight` is the registered copy of `Read_EN` from the previous cycle.
- Each issued read decrements `remaining` and increments `words_read`.
- `Read_EN` is never high while `Empty`=1, while in IDLE, DRAIN or DONE, or during reset.
- Buffer behaviour:
  - The cycle after `Read_EN`, `Read_Data` is written into the 2-entry buffer.
  - The buffer head drives `out_data`, and `out_valid` = (occ>0).
  - A pop happens on `out_valid && out_ready`.
  - A simultaneous push and pop leaves `occ` unchanged.
  - The buffer can never overflow. This is guaranteed by the issue rule, and the bench asserts it.
- Ordering: words leave in exactly FIFO order. There is no drop and no duplication.
- `out_data` holds its last value while `out_valid`=0.
- `out_valid`, once high, stays high and `out_data` stays stable until accepted.
- `Empty` rising mid-burst: reads stall, and `busy` stays high indefinitely until data arrives. There is no timeout.
- Widths: `remaining` and `words_read` are ADDR_WIDTH+1 bits. `burst_len`=2**ADDR_WIDTH (a full FIFO) is legal. No wrap occurs within a burst.

## Timing
- Reset values (asynchronous): state=IDLE, `Read_EN`=0, inflight=0, occ=0, `out_valid`=0, `out_data`=0, `busy`=0, `done`=0, `words_read`=0.
- Reset mid-burst aborts immediately. Words already popped from the FIFO and not yet delivered are discarded.
- Latency with `Empty`=0 and `out_ready`=1:
  - cycle 0: `start` is sampled.
  - cycle 1: READ state, `Read_EN`=1.
  - cycle 2: data captured.
  - cycle 3: first `out_valid`.
- Throughput: one word per cycle with `out_ready` held high.
- `done` asserts the cycle after the last word is accepted. `busy` is deasserted the cycle after `done`.
- For a `burst_len`=0 request: `busy`=1 in cycle 1, `done`=1 in cycle 1, IDLE in cycle 2. No `Read_EN` is issued.
- Back-to-back bursts: a `start` in the cycle after `done` is accepted.

## Test plan
- Reset, then FIFO preloaded with 0x0001..0x0004, `burst_len`=4, `out_ready`=1: `out_valid` in cycles 3..6 with data 0x0001..0x0004 in order; `done` in cycle 7; `words_read`=4; `Read_EN` high for exactly 4 cycles.
- Same burst with `out_ready` toggling 1,0,1,0: all 4 words delivered in order; `out_data` stable while stalled; occ never exceeds 2; `Read_EN` throttled accordingly.
- `burst_len`=3 with the FIFO holding only 1 word, remaining words written 10 cycles later: `Read_EN` stays 0 while `Empty`=1; burst completes after the writes; 3 words delivered.
- `burst_len`=0: `done` pulses, `Read_EN` never asserts, `words_read`=0. A `start` pulsed while busy in another burst is ignored.
- Full FIFO (32 words, ADDR_WIDTH=5), `burst_len`=32: 32 consecutive words delivered; `Empty` asserted afterwards; `Read_EN` never coincides with `Empty`=1.
- `rst_n` asserted in the middle of a burst: all outputs return to their reset values asynchronously; a new burst after reset runs normally.
